// File: rtl/bluetile_pkg.sv
// Shared opcodes, response tags, header field positions and server FSM states for the
// bluetile memory server.
package bluetile_pkg;

    localparam logic [7:0] OpWrite  = 8'h01;
    localparam logic [7:0] OpRead   = 8'h02;

    localparam logic [7:0] TagWrAck = 8'hA1;
    localparam logic [7:0] TagRdHdr = 8'hA2;
    localparam logic [7:0] TagErr   = 8'hEE;

    localparam int unsigned OpMsb   = 31;
    localparam int unsigned OpLsb   = 24;
    localparam int unsigned LenMsb  = 23;
    localparam int unsigned LenLsb  = 16;
    localparam int unsigned AddrMsb = 15;
    localparam int unsigned AddrLsb = 0;

    typedef enum logic [2:0] {
        StIdle,
        StWrData,
        StWrAck,
        StRdHdr,
        StRdData,
        StDrain,
        StErrRsp
    } srv_state_e;

    // len_addr is the stored {LEN, ADDR} portion of the request header.
    function automatic logic [31:0] rsp_word(input logic [7:0] tag, input logic [23:0] len_addr);
        return {tag, len_addr};
    endfunction

endpackage

// File: rtl/bluetile_regfile.sv
// DEPTH x 32 register array: one synchronous write port, one combinational read port.
module bluetile_regfile #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    // No reset: contents survive RST by design.
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bluetile_server_mem.sv
// Request/response memory server: WRITE/READ bursts over a DEPTH-word register array.
// Optional BT_SERVER_ERRCHK_EN adds an error response for unknown opcodes.
module bluetile_server_mem
    import bluetile_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] request_DIN,
    input  logic        request_valid,
    output logic        request_accept,
    output logic [31:0] response_DOUT,
    input  logic        response_canaccept,
    output logic        response_commit
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef BT_SERVER_ERRCHK_EN
    localparam srv_state_e DrainExit = StErrRsp;
`else
    localparam srv_state_e DrainExit = StIdle;
`endif

    srv_state_e     state_q, state_d;
    logic [23:0]    hdr_q, hdr_d;
    logic [7:0]     cnt_q, cnt_d;

    logic [7:0]     in_op;
    logic [7:0]     in_len;
    logic [7:0]     len;
    logic           last;
    logic [AW-1:0]  mem_addr;
    logic           mem_we;
    logic [31:0]    mem_rdata;

    assign in_op    = request_DIN[OpMsb:OpLsb];
    assign in_len   = request_DIN[LenMsb:LenLsb];
    assign len      = hdr_q[LenMsb:LenLsb];
    assign last     = (cnt_q == len - 8'd1);
    // Upper ADDR bits only matter for the echoed header, not for storage.
    assign mem_addr = hdr_q[AW-1:0] + AW'(cnt_q);

    always_comb begin
        state_d         = state_q;
        hdr_d           = hdr_q;
        cnt_d           = cnt_q;
        request_accept  = 1'b0;
        response_commit = 1'b0;
        response_DOUT   = 32'h0;
        mem_we          = 1'b0;

        unique case (state_q)
            StIdle: begin
                request_accept = 1'b1;
                if (request_valid) begin
                    hdr_d = request_DIN[23:0];
                    cnt_d = 8'd0;
                    if (in_op == OpWrite) begin
                        state_d = (in_len != 8'd0) ? StWrData : StWrAck;
                    end else if (in_op == OpRead) begin
                        state_d = StRdHdr;
                    end else if (in_len != 8'd0) begin
                        state_d = StDrain;
                    end else begin
                        state_d = DrainExit;
                    end
                end
            end
            StWrData: begin
                request_accept = 1'b1;
                if (request_valid) begin
                    mem_we = 1'b1;
                    if (last) begin
                        state_d = StWrAck;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StWrAck: begin
                response_DOUT   = rsp_word(TagWrAck, hdr_q);
                response_commit = response_canaccept;
                if (response_canaccept) begin
                    state_d = StIdle;
                end
            end
            StRdHdr: begin
                response_DOUT   = rsp_word(TagRdHdr, hdr_q);
                response_commit = response_canaccept;
                if (response_canaccept) begin
                    state_d = (len != 8'd0) ? StRdData : StIdle;
                    cnt_d   = 8'd0;
                end
            end
            StRdData: begin
                response_DOUT   = mem_rdata;
                response_commit = response_canaccept;
                if (response_canaccept) begin
                    if (last) begin
                        state_d = StIdle;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StDrain: begin
                request_accept = 1'b1;
                if (request_valid) begin
                    if (last) begin
                        state_d = DrainExit;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
`ifdef BT_SERVER_ERRCHK_EN
            StErrRsp: begin
                response_DOUT   = rsp_word(TagErr, hdr_q);
                response_commit = response_canaccept;
                if (response_canaccept) begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Nothing transfers or gets written during a reset cycle.
        if (RST) begin
            request_accept  = 1'b0;
            response_commit = 1'b0;
            response_DOUT   = 32'h0;
            mem_we          = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            hdr_q   <= 24'h0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            cnt_q   <= cnt_d;
        end
    end

    bluetile_regfile #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk_i   (CLK),
        .we_i    (mem_we),
        .waddr_i (mem_addr),
        .wdata_i (request_DIN),
        .raddr_i (mem_addr),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_bluetile_server_mem.sv
// Self-checking bench for bluetile_server_mem: directed and random bursts against a memory model.
module tb_bluetile_server_mem;

    localparam int DEPTH = 64;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] request_DIN;
    logic        request_valid;
    logic        request_accept;
    logic [31:0] response_DOUT;
    logic        response_canaccept;
    logic        response_commit;

    always #5 CLK = ~CLK;

    bluetile_server_mem #(
        .DEPTH (DEPTH)
    ) dut (
        .CLK                (CLK),
        .RST                (RST),
        .request_DIN        (request_DIN),
        .request_valid      (request_valid),
        .request_accept     (request_accept),
        .response_DOUT      (response_DOUT),
        .response_canaccept (response_canaccept),
        .response_commit    (response_commit)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] req_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] rsp_q[$];
    logic [31:0] data_q[$];
    int          rsp_cyc[$];
    int          acc_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Offer queued request words and collect n_rsp responses, then watch a few idle cycles.
    task automatic run(input string tag, input int n_rsp, input bit rnd_ca);
        int          budget;
        int          extra;
        logic        ca;
        logic [31:0] held;
        bit          held_v;
        bit          pending;
        budget = 3000;
        held   = 32'h0;
        held_v = 1'b0;
        rsp_q.delete();
        rsp_cyc.delete();
        acc_cyc.delete();
        while ((req_q.size() != 0 || rsp_q.size() < n_rsp) && budget > 0) begin
            pending            = (req_q.size() == 0);
            ca                 = rnd_ca ? 1'($urandom_range(0, 1)) : 1'b1;
            request_valid      = (req_q.size() != 0);
            request_DIN        = request_valid ? req_q[0] : 32'h0;
            response_canaccept = ca;
            #1;
            if (!ca) check({tag, " commit_without_canaccept"}, {31'd0, response_commit}, 32'd0);
            if (pending) begin
                check({tag, " accept_while_responding"}, {31'd0, request_accept}, 32'd0);
                if (held_v) check({tag, " dout_hold"}, response_DOUT, held);
                held   = response_DOUT;
                held_v = !response_commit;
            end
            if (request_valid && request_accept) begin
                void'(req_q.pop_front());
                acc_cyc.push_back(cyc);
            end
            if (response_commit) begin
                rsp_q.push_back(response_DOUT);
                rsp_cyc.push_back(cyc);
            end
            @(posedge CLK);
            #1;
            cyc++;
            budget--;
        end
        check({tag, " timeout"}, {31'd0, budget > 0}, 32'd1);
        request_valid      = 1'b0;
        request_DIN        = 32'h0;
        response_canaccept = 1'b1;
        extra              = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (i == 0) check({tag, " accept_after"}, {31'd0, request_accept}, 32'd1);
            if (response_commit) extra++;
            @(posedge CLK);
            #1;
            cyc++;
        end
        check({tag, " extra_responses"}, 32'(extra), 32'd0);
    endtask

    task automatic txn(input string tag, input logic [7:0] op, input logic [7:0] len,
                       input logic [15:0] addr, input bit rnd_ca);
        logic [31:0] d;
        int          n;
        exp_q.delete();
        req_q.delete();
        req_q.push_back({op, len, addr});
        if (op == 8'h01) begin
            for (int k = 0; k < int'(len); k++) begin
                d = (data_q.size() != 0) ? data_q.pop_front() : $urandom;
                req_q.push_back(d);
                mem_m[(int'(addr) + k) % DEPTH] = d;
            end
            exp_q.push_back({8'hA1, len, addr});
        end else if (op == 8'h02) begin
            exp_q.push_back({8'hA2, len, addr});
            for (int k = 0; k < int'(len); k++) exp_q.push_back(mem_m[(int'(addr) + k) % DEPTH]);
        end else begin
            for (int k = 0; k < int'(len); k++) req_q.push_back($urandom);
`ifdef BT_SERVER_ERRCHK_EN
            exp_q.push_back({8'hEE, len, addr});
`endif
        end
        run(tag, exp_q.size(), rnd_ca);
        check({tag, " rsp_count"}, 32'(rsp_q.size()), 32'(exp_q.size()));
        n = (rsp_q.size() < exp_q.size()) ? rsp_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, " rsp_word"}, rsp_q[i], exp_q[i]);
            if (!rnd_ca && acc_cyc.size() != 0)
                check({tag, " rsp_cycle"}, 32'(rsp_cyc[i]), 32'(acc_cyc[acc_cyc.size() - 1] + 1 + i));
        end
    endtask

    initial begin
        logic [7:0]  op;
        logic [7:0]  len;
        int          r;
        RST                = 1'b1;
        request_valid      = 1'b0;
        request_DIN        = 32'h0;
        response_canaccept = 1'b1;
        @(posedge CLK);
        #1;
        check("reset_commit_during", {31'd0, response_commit}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("reset_accept", {31'd0, request_accept}, 32'd1);
        check("reset_commit", {31'd0, response_commit}, 32'd0);
        check("reset_dout", response_DOUT, 32'h0);

        // Fill the whole array so every later read has a known expectation.
        txn("fill", 8'h01, 8'd64, 16'h0000, 1'b0);

        data_q = '{32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003};
        txn("wr3", 8'h01, 8'd3, 16'h0010, 1'b0);
        check("wr3_ack", rsp_q.size() != 0 ? rsp_q[0] : 32'h0, 32'hA1030010);
        txn("rd3", 8'h02, 8'd3, 16'h0010, 1'b0);

        data_q = '{32'h00000011};
        txn("wr63", 8'h01, 8'd1, 16'h003F, 1'b0);
        data_q = '{32'h00000022};
        txn("wr0", 8'h01, 8'd1, 16'h0000, 1'b0);
        txn("rd_wrap", 8'h02, 8'd2, 16'h003F, 1'b0);
        check("rd_wrap_d0", rsp_q.size() > 1 ? rsp_q[1] : 32'h0, 32'h00000011);
        check("rd_wrap_d1", rsp_q.size() > 2 ? rsp_q[2] : 32'h0, 32'h00000022);

        txn("rd_backpressure", 8'h02, 8'd5, 16'hAB3C, 1'b1);
        txn("bad_op", 8'h7F, 8'd2, 16'h1234, 1'b0);
        txn("bad_op_len0", 8'h7F, 8'd0, 16'h0042, 1'b0);
        txn("wr_len0", 8'h01, 8'd0, 16'h00FF, 1'b0);
        txn("rd_len0", 8'h02, 8'd0, 16'h0003, 1'b1);
        txn("rd_after_bad", 8'h02, 8'd4, 16'h0010, 1'b0);

        // Reset after the first of three write-data words.
        req_q.delete();
        data_q.delete();
        req_q.push_back(32'h01030020);
        req_q.push_back(32'hC0FFEE01);
        mem_m[32] = 32'hC0FFEE01;
        run("wr_abort", 0, 1'b0);
        RST = 1'b1;
        #1;
        check("rst_mid_commit", {31'd0, response_commit}, 32'd0);
        @(posedge CLK);
        #1;
        cyc++;
        RST = 1'b0;
        #1;
        check("rst_mid_accept", {31'd0, request_accept}, 32'd1);
        check("rst_mid_dout", response_DOUT, 32'h0);
        txn("rd_after_abort", 8'h02, 8'd3, 16'h0020, 1'b0);

        for (int t = 0; t < 30; t++) begin
            r   = $urandom_range(0, 9);
            len = 8'($urandom_range(0, 9));
            if (r < 4) op = 8'h01;
            else if (r < 8) op = 8'h02;
            else op = 8'h80 | 8'($urandom_range(0, 127));
            txn($sformatf("rand%0d", t), op, len, 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
